// File: rtl/tlp_hdr_serializer_if.sv
// Request, payload and transmit stream signals of the TLP header serializer.
// slave = serializer side, master = upstream/sink environment side.
interface tlp_hdr_serializer_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [2:0]  tlp_fmt;
  logic [4:0]  tlp_type;
  logic [2:0]  tlp_TC;
  logic        tlp_TD;
  logic        tlp_EP;
  logic [1:0]  tlp_Attr;
  logic [9:0]  tlp_length;
  logic [15:0] requester_id;
  logic [7:0]  tag;
  logic [3:0]  first_be;
  logic [3:0]  last_be;
  logic [63:0] addr;
  logic        pl_valid;
  logic        pl_ready;
  logic [31:0] pl_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;

  modport slave (
    input  hdr_valid, tlp_fmt, tlp_type, tlp_TC, tlp_TD, tlp_EP, tlp_Attr,
           tlp_length, requester_id, tag, first_be, last_be, addr,
           pl_valid, pl_data, tx_ready,
    output hdr_ready, pl_ready, tx_valid, tx_data, tx_sop, tx_eop
  );

  modport master (
    output hdr_valid, tlp_fmt, tlp_type, tlp_TC, tlp_TD, tlp_EP, tlp_Attr,
           tlp_length, requester_id, tag, first_be, last_be, addr,
           pl_valid, pl_data, tx_ready,
    input  hdr_ready, pl_ready, tx_valid, tx_data, tx_sop, tx_eop
  );
endinterface

// File: rtl/tlp_hdr_serializer.sv
// Packs a decoded TLP request into a 3DW/4DW header and streams it plus payload.
// Define TLP_ECRC_EN to append a CRC-32 digest DW to TLPs with TD=1.
//   state     | meaning
//   S_IDLE    | ready for a request; prefix formats rejected with fmt_err
//   S_HDR     | emitting registered header DWs, idx_q selects the DW
//   S_PAYLOAD | pl_* passed straight through to tx_*, cnt_q DWs left
//   S_DIGEST  | emitting the inverted ECRC (TLP_ECRC_EN builds only)
module tlp_hdr_serializer #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tlp_hdr_serializer_if.slave  bus,
  output logic                 fmt_err,
  output logic [CNT_W-1:0]     pkt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2
`ifdef TLP_ECRC_EN
    , S_DIGEST = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              init_q, init_d;
  logic [1:0]        idx_q, idx_d;
  logic              four_q, four_d;
  logic              wr_q, wr_d;
  logic [31:0]       dw1_q, dw1_d;
  logic [63:2]       addr_q, addr_d;
  logic [10:0]       cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              fmt_err_q, fmt_err_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic              hs_in, tx_hs, last_hdr, td_in;
  logic [31:0]       dw0_in, hdr_next;

`ifdef TLP_ECRC_EN
  logic              td_q, td_d;
  logic [31:0]       crc_q, crc_d, crc_upd;

  function automatic logic [31:0] crc32_dw(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  assign td_in   = bus.tlp_TD;
  assign crc_upd = crc32_dw(crc_q, bus.tx_data);
`else
  logic unused_td;
  assign td_in     = 1'b0;
  assign unused_td = bus.tlp_TD;
`endif

  logic unused_addr;
  assign unused_addr = ^bus.addr[1:0];

  assign hs_in    = bus.hdr_valid && bus.hdr_ready;
  assign tx_hs    = bus.tx_valid && bus.tx_ready;
  assign last_hdr = (idx_q == (four_q ? 2'd3 : 2'd2));
  assign dw0_in   = {bus.tlp_fmt, bus.tlp_type, 1'b0, bus.tlp_TC, 4'b0, td_in,
                     bus.tlp_EP, bus.tlp_Attr, 2'b0, bus.tlp_length};

  always_comb begin
    hdr_next = {addr_q[31:2], 2'b00};
    case (idx_q)
      2'd0:    hdr_next = dw1_q;
      2'd1:    hdr_next = four_q ? addr_q[63:32] : {addr_q[31:2], 2'b00};
      default: hdr_next = {addr_q[31:2], 2'b00};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      init_q    <= 1'b0;
      idx_q     <= '0;
      four_q    <= 1'b0;
      wr_q      <= 1'b0;
      dw1_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      fmt_err_q <= 1'b0;
      pkt_cnt_q <= '0;
`ifdef TLP_ECRC_EN
      td_q      <= 1'b0;
      crc_q     <= '1;
`endif
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      idx_q     <= idx_d;
      four_q    <= four_d;
      wr_q      <= wr_d;
      dw1_q     <= dw1_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      fmt_err_q <= fmt_err_d;
      pkt_cnt_q <= pkt_cnt_d;
`ifdef TLP_ECRC_EN
      td_q      <= td_d;
      crc_q     <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    init_d    = 1'b1;
    idx_d     = idx_q;
    four_d    = four_q;
    wr_d      = wr_q;
    dw1_d     = dw1_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    fmt_err_d = 1'b0;
    pkt_cnt_d = (tx_hs && bus.tx_eop) ? pkt_cnt_q + CNT_W'(1) : pkt_cnt_q;
`ifdef TLP_ECRC_EN
    td_d      = td_q;
    crc_d     = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (hs_in) begin
          if (bus.tlp_fmt[2]) begin
            fmt_err_d = 1'b1;
          end else begin
            state_d = S_HDR;
            idx_d   = 2'd0;
            four_d  = bus.tlp_fmt[0];
            wr_d    = bus.tlp_fmt[1];
            dw1_d   = {bus.requester_id, bus.tag, bus.last_be, bus.first_be};
            addr_d  = bus.addr[63:2];
            // length 0 encodes 1024 DWs
            cnt_d   = {(bus.tlp_length == 10'd0), bus.tlp_length};
            data_d  = dw0_in;
`ifdef TLP_ECRC_EN
            td_d    = bus.tlp_TD;
            crc_d   = '1;
`endif
          end
        end
      end
      S_HDR: begin
        if (tx_hs) begin
`ifdef TLP_ECRC_EN
          crc_d = crc_upd;
`endif
          if (!last_hdr) begin
            idx_d  = idx_q + 2'd1;
            data_d = hdr_next;
          end else if (wr_q) begin
            state_d = S_PAYLOAD;
`ifdef TLP_ECRC_EN
          end else if (td_q) begin
            state_d = S_DIGEST;
            data_d  = ~crc_upd;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (tx_hs) begin
          cnt_d = cnt_q - 11'd1;
`ifdef TLP_ECRC_EN
          crc_d = crc_upd;
`endif
          if (cnt_q == 11'd1) begin
`ifdef TLP_ECRC_EN
            if (td_q) begin
              state_d = S_DIGEST;
              data_d  = ~crc_upd;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef TLP_ECRC_EN
      S_DIGEST: begin
        if (tx_hs) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.hdr_ready = init_q && (state_q == S_IDLE);
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.tx_sop    = 1'b0;
    bus.tx_eop    = 1'b0;
    bus.pl_ready  = 1'b0;
    case (state_q)
      S_HDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = data_q;
        bus.tx_sop   = (idx_q == 2'd0);
`ifdef TLP_ECRC_EN
        bus.tx_eop   = last_hdr && !wr_q && !td_q;
`else
        bus.tx_eop   = last_hdr && !wr_q;
`endif
      end
      S_PAYLOAD: begin
        bus.tx_valid = bus.pl_valid;
        bus.tx_data  = bus.pl_data;
        bus.pl_ready = bus.tx_ready;
`ifdef TLP_ECRC_EN
        bus.tx_eop   = (cnt_q == 11'd1) && !td_q;
`else
        bus.tx_eop   = (cnt_q == 11'd1);
`endif
      end
`ifdef TLP_ECRC_EN
      S_DIGEST: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = data_q;
        bus.tx_eop   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign fmt_err = fmt_err_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: doc/tlp_hdr_serializer.md
# tlp_hdr_serializer

Transmit-side stage downstream of the TLP header decoder/manager. It accepts one fully decoded TLP request per handshake: fmt/type, traffic class, TD/EP, attributes, length, requester ID, tag, byte enables and address. It packs these into a 3DW or 4DW PCIe header and streams it, followed by any payload DWs, on a 32-bit valid/ready interface toward the data-link layer.

## Interface
- `CNT_W`, 16, width of the transmitted-packet counter
- `clk`  in  1  clock; all logic is rising-edge
- `rst`  in  1  asynchronous, active-low reset
- `hdr_valid`  in  1  request fields valid
- `hdr_ready`  out  1  block can accept a request
- `tlp_fmt`  in  3  Fmt field
- `tlp_type`  in  5  Type field
- `tlp_TC`  in  3  traffic class
- `tlp_TD`  in  1  digest present
- `tlp_EP`  in  1  poisoned
- `tlp_Attr`  in  2  attributes
- `tlp_length`  in  10  payload length in DW; 0 means 1024
- `requester_id`  in  16  requester ID
- `tag`  in  8  tag
- `first_be`, `last_be`  in  4 each  byte enables
- `addr`  in  64  address
- `pl_valid`  in  1  payload DW valid
- `pl_ready`  out  1  payload DW consumed
- `pl_data`  in  32  payload DW
- `tx_valid`  out  1  output beat valid
- `tx_ready`  in  1  sink accepts beat
- `tx_data`  out  32  output DW
- `tx_sop`  out  1  first beat of TLP
- `tx_eop`  out  1  last beat of TLP
- `fmt_err`  out  1  one-cycle pulse: request rejected
- `pkt_cnt`  out  CNT_W  count of TLPs completed, wraps

## Operation
- FSM states: IDLE, HDR, PAYLOAD, DIGEST (DIGEST exists only with the macro).
- IDLE: `hdr_ready`=1. A handshake latches all fields.
  - If `tlp_fmt[2]`=1 (prefix formats are unsupported), pulse `fmt_err` and stay in IDLE.
  - Otherwise go to HDR with beat index 0.
- Header DW count is 3 if `fmt[0]`=0, else 4.
- DW0 = {fmt, type, 1'b0, TC, 4'b0, TD, EP, Attr, 2'b0, length}.
- DW1 = {requester_id, tag, last_be, first_be}.
- 3DW header: DW2 = {addr[31:2], 2'b00}.
- 4DW header: DW2 = addr[63:32], DW3 = {addr[31:2], 2'b00}.
- HDR advances one DW per `tx_valid && tx_ready`. After the last header DW:
  - if `fmt[1]`=1, go to PAYLOAD;
  - else go to DIGEST if TD=1 (macro on), else IDLE.
- PAYLOAD:
  - Pass-through: `tx_valid`=`pl_valid`, `tx_data`=`pl_data`, `pl_ready`=`tx_ready`.
  - An 11-bit down-counter is loaded with length (0 maps to 1024).
  - After the last payload beat, go to DIGEST or IDLE.
- `tx_sop`=1 on header DW0 only. `tx_eop`=1 on the final beat (header, payload or digest).
- `pkt_cnt` increments on the EOP handshake and wraps from all-ones to 0.
- `pl_ready`=0 outside PAYLOAD.

## Timing
- Reset values: `hdr_ready`=0 while reset is asserted and 1 from the first clock after release; `tx_valid`=0, `tx_sop`=0, `tx_eop`=0, `pl_ready`=0, `fmt_err`=0, `pkt_cnt`=0, `tx_data`=0, state IDLE.
- Latency: DW0 is on `tx_data` with `tx_valid`=1 in the cycle after the `hdr_valid && hdr_ready` handshake.
- Header and digest beats are registered.
  - While `tx_valid && !tx_ready`, `tx_data`, `tx_sop` and `tx_eop` hold stable.
  - `tx_valid` never drops without a handshake.
- Payload beats are combinational pass-through, with zero added latency.
- After EOP, the block returns to IDLE with `hdr_ready`=1 in the following cycle: exactly one bubble cycle between TLPs.
- `fmt_err` asserts the cycle after the handshake and lasts one cycle.
- Reset asserted mid-packet aborts immediately. All outputs take their reset values and no EOP is emitted.

## Configuration
- `TLP_ECRC_EN` defined:
  - A CRC-32 (polynomial 0x04C11DB7, init 0xFFFFFFFF, MSB-first, final inversion) runs over every emitted header and payload DW of a TLP with TD=1.
  - The inverted CRC is appended as one extra DW with `tx_eop`=1.
- `TLP_ECRC_EN` undefined:
  - DW0 bit 15 is forced to 0 regardless of `tlp_TD`.
  - The DIGEST state and CRC logic are absent.

## Test plan
- 3DW memory read: fmt=000, type=00000, length=1, addr=0x0000_0000_1234_5678, req_id=0x0100, tag=0x05, first_be=F, last_be=0 -> 3 beats 0x00000001, 0x0100050F, 0x12345678; sop on beat 0, eop on beat 2; pkt_cnt=1.
- 4DW write, length=2, `tx_ready` toggling every cycle -> 6 beats, each held stable while stalled, `pl_ready` high only when `tx_ready`=1, eop on payload DW2.
- length=0 write -> exactly 1024 payload beats, eop on the 1024th.
- fmt=100 request -> `fmt_err` pulse one cycle, no `tx_valid`, pkt_cnt unchanged.
- ECRC on, 3DW read with TD=1 -> DW0 bit15=1, a 4th beat carries CRC matching the reference model, eop on it. ECRC off -> bit15=0 and 3 beats.
- Reset asserted after header DW1 -> `tx_valid`=0 immediately; after release a new TLP starts with sop and pkt_cnt=0.
